lcd_i8080_target: RTL and testbench

Bus-side responder for the 16-bit 8080-style LCD interface driven by the SoC's APB LCD pin controller. It samples CS/RS/WR/RD/RST asynchronously to PCLK, decodes write strobes into a command/data FIFO and answers read strobes by driving the data bus. Sits on the display side of the pins as an in-system loopback target and as the verification model for LCD firmware drivers.

---
 rtl/lcd_tgt_pkg.sv | 23 ++
 rtl/lcd_i8080_target_if.sv | 24 ++
 rtl/lcd_tgt_fifo.sv | 60 ++++++
 rtl/lcd_i8080_target.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_i8080_target.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_tgt_pkg.sv
// Shared definitions for the 8080 LCD bus target: bus FSM encoding,
// capture FIFO entry layout and synchronizer reset values.
package lcd_tgt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WR_ACTIVE = 2'd1,
        ST_RD_ACTIVE = 2'd2
    } bus_state_t;

    // Entry layout: bit 16 = command flag (RS was 0), bits 15:0 = bus data.
    localparam int ENTRY_W = 17;

    // Control pins idle high, so their synchronizers come out of reset
    // looking like an idle bus; data synchronizers reset to zero.
    localparam logic        CTRL_SYNC_RST = 1'b1;
    localparam logic [15:0] DATA_SYNC_RST = 16'h0000;

    function automatic logic [ENTRY_W-1:0] make_entry(input logic rs, input logic [15:0] data);
        return {~rs, data};
    endfunction

endpackage

// File: rtl/lcd_i8080_target_if.sv
// Pin-level 8080 LCD bus bundle. The initiator (pin controller or bench)
// uses the master modport, the display-side target uses slave.
interface lcd_i8080_target_if;

    logic        LCD_CS;
    logic        LCD_RS;
    logic        LCD_WR;
    logic        LCD_RD;
    logic        LCD_RST;
    logic [15:0] LCD_DATA_IN;
    logic [15:0] LCD_DATA_OUT;
    logic        LCD_DATA_OE;

    modport master (
        output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_DATA_IN,
        input  LCD_DATA_OUT, LCD_DATA_OE
    );

    modport slave (
        input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_DATA_IN,
        output LCD_DATA_OUT, LCD_DATA_OE
    );

endinterface

// File: rtl/lcd_tgt_fifo.sv
// Synchronous capture FIFO. Flush has priority over everything; a pop in
// the same cycle frees room, so push into a full FIFO with a pop is taken.
// Head output reads zero while empty.
module lcd_tgt_fifo
    import lcd_tgt_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             accept
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign accept  = do_push;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/lcd_i8080_target.sv
// Display-side responder for the 16-bit 8080 LCD bus. Synchronizes the
// pins into PCLK, captures write strobes into a command/data FIFO and
// answers read strobes on the data bus.
// Optional feature macro: LCD_TGT_CMD_TRACK_EN (last command / data count
// tracking; when undefined both read as zero).
module lcd_i8080_target
    import lcd_tgt_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    lcd_i8080_target_if.slave lcd,
    input  logic [15:0]       RSP_DATA,
    output logic              RX_VALID,
    input  logic              RX_READY,
    output logic              RX_IS_CMD,
    output logic [15:0]       RX_DATA,
    output logic              RD_STROBE,
    output logic              OVERFLOW,
    output logic              PROTO_ERR,
    input  logic              FLAG_CLR,
    output logic              PANEL_RST_N,
    output logic [15:0]       DATA_CNT
);

    logic        cs_q1, cs_q2;
    logic        rs_q1, rs_q2;
    logic        rst_q1, rst_q2;
    logic        wr_q1, wr_q2, wr_q3;
    logic        rd_q1, rd_q2, rd_q3;
    logic [15:0] data_q1, data_q2;

    bus_state_t  state, state_next;
    logic        push_req, rd_start, proto_set;
    logic        push_q;
    logic [ENTRY_W-1:0] push_entry_q;
    logic        oe_q;
    logic [15:0] data_out_q;
    logic        strobe_q;
    logic        ovf_q, perr_q, panel_rst_q;
    logic [ENTRY_W-1:0] fifo_head;
    logic        fifo_full, fifo_empty, fifo_accept;
    logic        fifo_pop;
    logic [15:0] cmd_rsp;

    logic wr_fall, wr_rise, rd_fall, rd_rise, proto_hit;

    assign wr_fall   = wr_q3 & ~wr_q2;
    assign wr_rise   = ~wr_q3 & wr_q2;
    assign rd_fall   = rd_q3 & ~rd_q2;
    assign rd_rise   = ~rd_q3 & rd_q2;
    assign proto_hit = rst_q2 & ~cs_q2 & ~wr_q2 & ~rd_q2;

    // Pin synchronizers; WR and RD keep a third stage for edge detection.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            cs_q1   <= CTRL_SYNC_RST;  cs_q2  <= CTRL_SYNC_RST;
            rs_q1   <= CTRL_SYNC_RST;  rs_q2  <= CTRL_SYNC_RST;
            rst_q1  <= CTRL_SYNC_RST;  rst_q2 <= CTRL_SYNC_RST;
            wr_q1   <= CTRL_SYNC_RST;  wr_q2  <= CTRL_SYNC_RST;  wr_q3 <= CTRL_SYNC_RST;
            rd_q1   <= CTRL_SYNC_RST;  rd_q2  <= CTRL_SYNC_RST;  rd_q3 <= CTRL_SYNC_RST;
            data_q1 <= DATA_SYNC_RST;  data_q2 <= DATA_SYNC_RST;
        end else begin
            cs_q1   <= lcd.LCD_CS;      cs_q2   <= cs_q1;
            rs_q1   <= lcd.LCD_RS;      rs_q2   <= rs_q1;
            rst_q1  <= lcd.LCD_RST;     rst_q2  <= rst_q1;
            wr_q1   <= lcd.LCD_WR;      wr_q2   <= wr_q1;   wr_q3 <= wr_q2;
            rd_q1   <= lcd.LCD_RD;      rd_q2   <= rd_q1;   rd_q3 <= rd_q2;
            data_q1 <= lcd.LCD_DATA_IN; data_q2 <= data_q1;
        end
    end

    // Bus FSM state register.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Bus FSM next state and one-cycle action requests. Panel reset and
    // protocol violations override whatever transfer is in progress.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        rd_start   = 1'b0;
        proto_set  = 1'b0;
        if (!rst_q2) begin
            state_next = ST_IDLE;
        end else if (proto_hit) begin
            state_next = ST_IDLE;
            proto_set  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cs_q2 && wr_fall && rd_q2) begin
                        state_next = ST_WR_ACTIVE;
                    end else if (!cs_q2 && rd_fall && wr_q2) begin
                        state_next = ST_RD_ACTIVE;
                        rd_start   = 1'b1;
                    end
                end
                ST_WR_ACTIVE: begin
                    if (wr_rise) begin
                        state_next = ST_IDLE;
                        push_req   = ~cs_q2;
                    end else if (cs_q2) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_RD_ACTIVE: begin
                    if (rd_rise || cs_q2) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Stage the captured entry so the FIFO write lands one cycle after the strobe edge.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q       <= push_req;
            push_entry_q <= make_entry(rs_q2, data_q2);
        end
    end

    // Read response: data latched at read start, drive enable follows the FSM.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            oe_q       <= 1'b0;
            data_out_q <= 16'h0000;
            strobe_q   <= 1'b0;
        end else begin
            oe_q     <= rst_q2 & (state == ST_RD_ACTIVE);
            strobe_q <= rd_start;
            if (rd_start) data_out_q <= rs_q2 ? RSP_DATA : cmd_rsp;
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (push_q && rst_q2 && !fifo_accept) ovf_q <= 1'b1;
            else if (FLAG_CLR)                    ovf_q <= 1'b0;
            if (proto_set)                        perr_q <= 1'b1;
            else if (FLAG_CLR)                    perr_q <= 1'b0;
        end
    end

    // Panel reset output: same latency as the second sync stage, but low out of reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) panel_rst_q <= 1'b0;
        else          panel_rst_q <= rst_q1;
    end

    assign fifo_pop = RX_VALID & RX_READY;

    lcd_tgt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .flush     (~rst_q2),
        .push      (push_q),
        .push_data (push_entry_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .accept    (fifo_accept)
    );

`ifdef LCD_TGT_CMD_TRACK_EN
    logic [7:0]  last_cmd;
    logic [15:0] data_cnt;

    // Track the most recent command byte and count data words accepted since it.
    always_ff @(posedge PCLK) begin
        if (!PRESETn || !rst_q2) begin
            last_cmd <= 8'h00;
            data_cnt <= 16'h0000;
        end else if (fifo_accept) begin
            if (push_entry_q[ENTRY_W-1]) begin
                last_cmd <= push_entry_q[7:0];
                data_cnt <= 16'h0000;
            end else begin
                data_cnt <= data_cnt + 16'd1;
            end
        end
    end

    assign cmd_rsp  = {8'h00, last_cmd};
    assign DATA_CNT = data_cnt;
`else
    assign cmd_rsp  = 16'h0000;
    assign DATA_CNT = 16'h0000;
`endif

    assign lcd.LCD_DATA_OUT = data_out_q;
    assign lcd.LCD_DATA_OE  = oe_q;
    assign RD_STROBE        = strobe_q;
    assign OVERFLOW         = ovf_q;
    assign PROTO_ERR        = perr_q;
    assign PANEL_RST_N      = panel_rst_q;
    assign RX_VALID         = ~fifo_empty;
    assign RX_IS_CMD        = fifo_head[ENTRY_W-1];
    assign RX_DATA          = fifo_head[15:0];

endmodule

// File: tb/tb_lcd_i8080_target.sv
// Directed bench for lcd_i8080_target: pin bit-banged writes/reads with
// table-driven expectations plus hand sequences for overflow, protocol
// error, aborted write and panel reset.
module tb_lcd_i8080_target;

`ifdef LCD_TGT_CMD_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [15:0] RSP_DATA = 16'h0000;
    logic        RX_VALID;
    logic        RX_READY = 1'b0;
    logic        RX_IS_CMD;
    logic [15:0] RX_DATA;
    logic        RD_STROBE;
    logic        OVERFLOW;
    logic        PROTO_ERR;
    logic        FLAG_CLR = 1'b0;
    logic        PANEL_RST_N;
    logic [15:0] DATA_CNT;

    lcd_i8080_target_if lcd();

    always #5 PCLK = ~PCLK;

    lcd_i8080_target #(.FIFO_DEPTH(8)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .lcd         (lcd),
        .RSP_DATA    (RSP_DATA),
        .RX_VALID    (RX_VALID),
        .RX_READY    (RX_READY),
        .RX_IS_CMD   (RX_IS_CMD),
        .RX_DATA     (RX_DATA),
        .RD_STROBE   (RD_STROBE),
        .OVERFLOW    (OVERFLOW),
        .PROTO_ERR   (PROTO_ERR),
        .FLAG_CLR    (FLAG_CLR),
        .PANEL_RST_N (PANEL_RST_N),
        .DATA_CNT    (DATA_CNT)
    );

    typedef struct {
        logic        rs;
        logic [15:0] data;
        logic        exp_cmd;
        logic [15:0] exp_data;
    } wr_vec_t;

    typedef struct {
        logic        rs;
        logic [15:0] rsp;
        logic [15:0] exp_data;
    } rd_vec_t;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    always @(negedge PCLK) if (RD_STROBE) strobe_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic pin_write(input logic rs, input logic [15:0] d);
        lcd.LCD_DATA_IN = d;
        lcd.LCD_RS      = rs;
        lcd.LCD_CS      = 1'b0;
        cyc(3);
        lcd.LCD_WR = 1'b0;
        cyc(4);
        lcd.LCD_WR = 1'b1;
        cyc(4);
        lcd.LCD_CS = 1'b1;
        cyc(3);
    endtask

    task automatic pin_read(input logic rs, input logic [15:0] rsp, input logic [15:0] exp, input string name);
        int s0;
        RSP_DATA   = rsp;
        lcd.LCD_RS = rs;
        lcd.LCD_CS = 1'b0;
        cyc(3);
        s0 = strobe_cnt;
        lcd.LCD_RD = 1'b0;
        cyc(6);
        check({name, "_oe_hi"}, 32'(lcd.LCD_DATA_OE), 32'd1);
        check({name, "_data"}, 32'(lcd.LCD_DATA_OUT), 32'(exp));
        lcd.LCD_RD = 1'b1;
        cyc(6);
        check({name, "_oe_lo"}, 32'(lcd.LCD_DATA_OE), 32'd0);
        check({name, "_strobes"}, 32'(strobe_cnt - s0), 32'd1);
        lcd.LCD_CS = 1'b1;
        cyc(3);
    endtask

    task automatic pop_expect(input logic is_cmd, input logic [15:0] d, input string name);
        int w = 0;
        while (!RX_VALID && w < 20) begin
            cyc(1);
            w++;
        end
        check({name, "_valid"}, 32'(RX_VALID), 32'd1);
        check({name, "_is_cmd"}, 32'(RX_IS_CMD), 32'(is_cmd));
        check({name, "_data"}, 32'(RX_DATA), 32'(d));
        RX_READY = 1'b1;
        cyc(1);
        RX_READY = 1'b0;
    endtask

    wr_vec_t wv[3];
    rd_vec_t rv[3];

    initial begin
        lcd.LCD_CS      = 1'b1;
        lcd.LCD_RS      = 1'b1;
        lcd.LCD_WR      = 1'b1;
        lcd.LCD_RD      = 1'b1;
        lcd.LCD_RST     = 1'b1;
        lcd.LCD_DATA_IN = 16'h0000;

        wv[0] = '{rs: 1'b0, data: 16'h002C, exp_cmd: 1'b1, exp_data: 16'h002C};
        wv[1] = '{rs: 1'b1, data: 16'h1234, exp_cmd: 1'b0, exp_data: 16'h1234};
        wv[2] = '{rs: 1'b1, data: 16'hABCD, exp_cmd: 1'b0, exp_data: 16'hABCD};

        rv[0] = '{rs: 1'b1, rsp: 16'h5A5A, exp_data: 16'h5A5A};
        rv[1] = '{rs: 1'b0, rsp: 16'hFFFF, exp_data: TRACK ? 16'h002C : 16'h0000};
        rv[2] = '{rs: 1'b1, rsp: 16'h1357, exp_data: 16'h1357};

        // Reset values.
        cyc(3);
        check("rst_rx_valid", 32'(RX_VALID), 32'd0);
        check("rst_rx_is_cmd", 32'(RX_IS_CMD), 32'd0);
        check("rst_rx_data", 32'(RX_DATA), 32'd0);
        check("rst_oe", 32'(lcd.LCD_DATA_OE), 32'd0);
        check("rst_data_out", 32'(lcd.LCD_DATA_OUT), 32'd0);
        check("rst_strobe", 32'(RD_STROBE), 32'd0);
        check("rst_overflow", 32'(OVERFLOW), 32'd0);
        check("rst_proto_err", 32'(PROTO_ERR), 32'd0);
        check("rst_panel_rst_n", 32'(PANEL_RST_N), 32'd0);
        check("rst_data_cnt", 32'(DATA_CNT), 32'd0);
        PRESETn = 1'b1;
        cyc(5);
        check("panel_rst_n_release", 32'(PANEL_RST_N), 32'd1);

        // Write latency: pin WR rise to RX_VALID is four PCLK edges.
        lcd.LCD_DATA_IN = 16'hBEEF;
        lcd.LCD_RS      = 1'b1;
        lcd.LCD_CS      = 1'b0;
        cyc(3);
        lcd.LCD_WR = 1'b0;
        cyc(4);
        lcd.LCD_WR = 1'b1;
        cyc(3);
        check("wr_lat_3", 32'(RX_VALID), 32'd0);
        cyc(1);
        check("wr_lat_4", 32'(RX_VALID), 32'd1);
        lcd.LCD_CS = 1'b1;
        cyc(3);
        pop_expect(1'b0, 16'hBEEF, "lat_pop");

        // Read latency: pin RD fall to OE, and RD rise to OE drop, four edges each.
        RSP_DATA   = 16'h0F0F;
        lcd.LCD_CS = 1'b0;
        cyc(3);
        lcd.LCD_RD = 1'b0;
        cyc(3);
        check("rd_lat_3", 32'(lcd.LCD_DATA_OE), 32'd0);
        cyc(1);
        check("rd_lat_4", 32'(lcd.LCD_DATA_OE), 32'd1);
        check("rd_lat_data", 32'(lcd.LCD_DATA_OUT), 32'h0F0F);
        lcd.LCD_RD = 1'b1;
        cyc(3);
        check("rd_rise_3", 32'(lcd.LCD_DATA_OE), 32'd1);
        cyc(1);
        check("rd_rise_4", 32'(lcd.LCD_DATA_OE), 32'd0);
        lcd.LCD_CS = 1'b1;
        cyc(3);

        // Command then two data words.
        for (int i = 0; i < 3; i++) pin_write(wv[i].rs, wv[i].data);
        check("seq_data_cnt", 32'(DATA_CNT), TRACK ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) pop_expect(wv[i].exp_cmd, wv[i].exp_data, $sformatf("seq%0d", i));
        cyc(1);
        check("seq_empty", 32'(RX_VALID), 32'd0);

        // Read responses for RS=1 and RS=0.
        for (int i = 0; i < 3; i++) pin_read(rv[i].rs, rv[i].rsp, rv[i].exp_data, $sformatf("rd%0d", i));

        // Overflow: eight fit, the ninth is dropped.
        for (int i = 0; i < 8; i++) pin_write(1'b1, 16'h0100 + 16'(i));
        check("ovf_at_full", 32'(OVERFLOW), 32'd0);
        pin_write(1'b1, 16'h0108);
        check("ovf_set", 32'(OVERFLOW), 32'd1);
        check("ovf_data_cnt", 32'(DATA_CNT), TRACK ? 32'd10 : 32'd0);
        for (int i = 0; i < 8; i++) pop_expect(1'b0, 16'h0100 + 16'(i), $sformatf("ovf%0d", i));
        cyc(1);
        check("ovf_drained", 32'(RX_VALID), 32'd0);
        check("ovf_sticky", 32'(OVERFLOW), 32'd1);
        FLAG_CLR = 1'b1;
        cyc(1);
        FLAG_CLR = 1'b0;
        check("ovf_cleared", 32'(OVERFLOW), 32'd0);

        // WR and RD low together with CS low.
        lcd.LCD_DATA_IN = 16'hDEAD;
        lcd.LCD_CS = 1'b0;
        cyc(3);
        lcd.LCD_WR = 1'b0;
        cyc(4);
        lcd.LCD_RD = 1'b0;
        cyc(5);
        check("perr_set", 32'(PROTO_ERR), 32'd1);
        check("perr_oe", 32'(lcd.LCD_DATA_OE), 32'd0);
        lcd.LCD_RD = 1'b1;
        cyc(4);
        lcd.LCD_WR = 1'b1;
        cyc(6);
        lcd.LCD_CS = 1'b1;
        cyc(3);
        check("perr_no_push", 32'(RX_VALID), 32'd0);
        check("perr_oe_after", 32'(lcd.LCD_DATA_OE), 32'd0);
        FLAG_CLR = 1'b1;
        cyc(1);
        FLAG_CLR = 1'b0;
        check("perr_cleared", 32'(PROTO_ERR), 32'd0);

        // CS rises before WR rises: write aborted.
        lcd.LCD_DATA_IN = 16'h4444;
        lcd.LCD_CS = 1'b0;
        cyc(3);
        lcd.LCD_WR = 1'b0;
        cyc(4);
        lcd.LCD_CS = 1'b1;
        cyc(4);
        lcd.LCD_WR = 1'b1;
        cyc(6);
        check("cs_abort_no_push", 32'(RX_VALID), 32'd0);

        // Panel reset with three entries queued.
        pin_write(1'b0, 16'h0011);
        pin_write(1'b1, 16'h0001);
        pin_write(1'b1, 16'h0002);
        check("lrst_queued", 32'(RX_VALID), 32'd1);
        check("lrst_cnt_before", 32'(DATA_CNT), TRACK ? 32'd2 : 32'd0);
        check("lrst_panel_before", 32'(PANEL_RST_N), 32'd1);
        lcd.LCD_RST = 1'b0;
        cyc(1);
        check("lrst_panel_1", 32'(PANEL_RST_N), 32'd1);
        cyc(1);
        check("lrst_panel_2", 32'(PANEL_RST_N), 32'd0);
        cyc(2);
        check("lrst_flushed", 32'(RX_VALID), 32'd0);
        check("lrst_cnt", 32'(DATA_CNT), 32'd0);
        pin_write(1'b1, 16'h7777);
        check("lrst_ignored", 32'(RX_VALID), 32'd0);
        check("lrst_flags", 32'(OVERFLOW | PROTO_ERR), 32'd0);
        lcd.LCD_RST = 1'b1;
        cyc(4);
        check("lrst_release", 32'(PANEL_RST_N), 32'd1);
        pin_read(1'b0, 16'hFFFF, 16'h0000, "rd_cmd_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
